mmc_arm_level_quantizer: RTL and testbench

//  Clocked, parametrised successor to the MMC leg insertion-index logic.
//  Per leg, converts normalised upper/lower arm drive samples into submodule insertion levels 0..N_SM.

---
 rtl/mmc_arm_level_quantizer.sv | 94 +++++++++
 tb/tb_mmc_arm_level_quantizer.sv | 104 ++++++++++
 2 files changed

// File: rtl/mmc_arm_level_quantizer.sv
// mmc_arm_level_quantizer: per-arm drive-to-insertion-level quantizer with hysteresis, slew limit and init load
module mmc_arm_level_quantizer #(
  parameter int N_LEG    = 3,
  parameter int N_SM     = 127,
  parameter int DRV_W    = 16,
  parameter int HYST     = 8192,
  parameter int MAX_STEP = 4,
  localparam int LW      = $clog2(N_SM+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   drv_valid,
  input  logic                   init,
  input  logic [N_LEG*DRV_W-1:0] drv_up,
  input  logic [N_LEG*DRV_W-1:0] drv_dw,
  output logic [N_LEG*LW-1:0]    lvl_up,
  output logic [N_LEG*LW-1:0]    lvl_dw,
  output logic                   lvl_valid,
  output logic [2*N_LEG-1:0]     slew_sat
);
  localparam int NA = 2*N_LEG;
  localparam int SW = DRV_W+LW;
  localparam int CW = SW+1;
  localparam logic [CW-1:0] HF = CW'(2**(DRV_W-1));
  localparam logic [CW-1:0] HY = CW'(HYST);
  localparam logic [LW:0] MS = (LW+1)'(MAX_STEP);
  localparam bit LIM = MAX_STEP != 0;
  logic v1_q, init1_q, lvl_valid_q;
  // sample flags through the two pipeline stages; init counts as a sample on its own
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      init1_q     <= 1'b0;
      lvl_valid_q <= 1'b0;
    end else begin
      v1_q        <= drv_valid | init;
      init1_q     <= init;
      lvl_valid_q <= v1_q;
    end
  end
  assign lvl_valid = lvl_valid_q;
  for (genvar a = 0; a < NA; a++) begin : g_arm
    logic [DRV_W-1:0] drv;
    logic [SW-1:0] scaled_d, scaled_q;
    logic [LW-1:0] tgt_d, tgt_q, lvl_d, lvl_q;
    logic sat_d, sat_q;
    logic [CW-1:0] cur, scl;
    logic [LW:0] up_lim, dn_lim;
    logic up, dn, up_clip, dn_clip;
    // scale drive to level units, round half up, then decide hysteresis step and slew clip
    always_comb begin
      drv      = (a % 2 == 1) ? drv_dw[(a/2)*DRV_W +: DRV_W] : drv_up[(a/2)*DRV_W +: DRV_W];
      scaled_d = SW'(drv) * SW'(N_SM);
      tgt_d    = LW'((CW'(scaled_d) + HF) >> DRV_W);
      cur      = {1'b0, lvl_q, DRV_W'(0)};
      scl      = {1'b0, scaled_q};
      up       = scl >= cur + HF + HY;
      dn       = (lvl_q != '0) && (scl + HF + HY < cur);
      up_lim   = {1'b0, lvl_q} + MS;
      dn_lim   = ({1'b0, lvl_q} >= MS) ? {1'b0, lvl_q} - MS : '0;
      up_clip  = LIM && (up_lim < {1'b0, tgt_q});
      dn_clip  = LIM && (dn_lim > {1'b0, tgt_q});
      lvl_d    = init1_q ? tgt_q : up ? (up_clip ? up_lim[LW-1:0] : tgt_q) :
                 dn ? (dn_clip ? dn_lim[LW-1:0] : tgt_q) : lvl_q;
      sat_d    = init1_q ? 1'b0 : up ? up_clip : dn ? dn_clip : sat_q;
    end
    // stage 1: capture scaled drive and rounded target on each sample
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        scaled_q <= '0;
        tgt_q    <= '0;
      end else if (drv_valid | init) begin
        scaled_q <= scaled_d;
        tgt_q    <= tgt_d;
      end
    end
    // stage 2: commit level and slew flag; both hold between samples
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lvl_q <= '0;
        sat_q <= 1'b0;
      end else if (v1_q) begin
        lvl_q <= lvl_d;
        sat_q <= sat_d;
      end
    end
    assign slew_sat[a] = sat_q;
    if (a % 2 == 1) begin : g_dw
      assign lvl_dw[(a/2)*LW +: LW] = lvl_q;
    end else begin : g_up
      assign lvl_up[(a/2)*LW +: LW] = lvl_q;
    end
  end
endmodule

// File: tb/tb_mmc_arm_level_quantizer.sv
// tb_mmc_arm_level_quantizer: directed vectors for the arm level quantizer
module tb_mmc_arm_level_quantizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv_valid = 1'b0;
  logic init = 1'b0;
  logic [47:0] drv_up = '0;
  logic [47:0] drv_dw = '0;
  logic [20:0] lvl_up, lvl_dw;
  logic lvl_valid;
  logic [5:0] slew_sat;
  int checks = 0;
  int errors = 0;
  logic [6:0] e_up0, e_up1, e_up2, e_dw2;
  logic c0, c5;
  logic [15:0] d_up1, d_up2;

  mmc_arm_level_quantizer #(.N_LEG(3), .N_SM(127), .DRV_W(16), .HYST(8192), .MAX_STEP(4)) dut (
    .clk(clk), .rst(rst), .drv_valid(drv_valid), .init(init),
    .drv_up(drv_up), .drv_dw(drv_dw), .lvl_up(lvl_up), .lvl_dw(lvl_dw),
    .lvl_valid(lvl_valid), .slew_sat(slew_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pk(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2);
    return {l2, l1, l0};
  endfunction

  function automatic logic [20:0] pl(input logic [6:0] l0, input logic [6:0] l1, input logic [6:0] l2);
    return {l2, l1, l0};
  endfunction

  task automatic sample(input logic ini, input logic vld, input logic [47:0] up, input logic [47:0] dw);
    @(posedge clk); #1;
    init = ini; drv_valid = vld; drv_up = up; drv_dw = dw;
    @(posedge clk); #1;
    init = 1'b0; drv_valid = 1'b0;
    check("lvl_valid_early", 32'(lvl_valid), 0);
    @(posedge clk); #1;
    check("lvl_valid", 32'(lvl_valid), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_lvl_up", 32'(lvl_up), 0);
    check("rst_lvl_dw", 32'(lvl_dw), 0);
    check("rst_valid", 32'(lvl_valid), 0);
    check("rst_slew", 32'(slew_sat), 0);
    rst = 1'b0;
    sample(1'b1, 1'b0, pk(16'h8000, 16'h8000, 16'h8000), pk(16'h8000, 16'd1548, 16'd5160));
    check("init_up", 32'(lvl_up), 32'(pl(7'd64, 7'd64, 7'd64)));
    check("init_dw", 32'(lvl_dw), 32'(pl(7'd64, 7'd3, 7'd10)));
    check("init_slew", 32'(slew_sat), 0);
    for (int i = 1; i <= 17; i++) begin
      d_up1 = (i == 1) ? 16'd33310 : 16'd33387;
      d_up2 = (i == 1) ? 16'd32950 : (i == 2) ? 16'd32870 : 16'd32700;
      sample(1'b0, 1'b1, pk(16'hFFFF, d_up1, d_up2), pk(16'h8000, 16'd0, 16'd0));
      e_up0 = (i <= 15) ? 7'(64 + 4*i) : 7'd127;
      c0    = (i <= 15);
      e_up1 = (i == 1) ? 7'd64 : 7'd65;
      e_up2 = (i <= 2) ? 7'd64 : 7'd63;
      e_dw2 = (i == 1) ? 7'd6 : (i == 2) ? 7'd2 : 7'd0;
      c5    = (i <= 2);
      check($sformatf("run%0d_up", i), 32'(lvl_up), 32'(pl(e_up0, e_up1, e_up2)));
      check($sformatf("run%0d_dw", i), 32'(lvl_dw), 32'(pl(7'd64, 7'd0, e_dw2)));
      check($sformatf("run%0d_slew", i), 32'(slew_sat), 32'({c5, 4'b0000, c0}));
    end
    sample(1'b0, 1'b1, pk(16'd0, 16'd33387, 16'd32700), pk(16'h8000, 16'd0, 16'd0));
    check("dn127_up", 32'(lvl_up), 32'(pl(7'd123, 7'd65, 7'd63)));
    check("dn127_slew", 32'(slew_sat), 32'(6'b000001));
    sample(1'b1, 1'b1, pk(16'h8000, 16'h8000, 16'h8000), pk(16'd0, 16'h8000, 16'hFFFF));
    check("init2_up", 32'(lvl_up), 32'(pl(7'd64, 7'd64, 7'd64)));
    check("init2_dw", 32'(lvl_dw), 32'(pl(7'd0, 7'd64, 7'd127)));
    check("init2_slew", 32'(slew_sat), 0);
    @(posedge clk); #1;
    drv_valid = 1'b1; drv_up = pk(16'hFFFF, 16'd0, 16'hFFFF);
    @(posedge clk); #1;
    drv_valid = 1'b0; rst = 1'b1;
    #1;
    check("midrst_up", 32'(lvl_up), 0);
    check("midrst_dw", 32'(lvl_dw), 0);
    check("midrst_slew", 32'(slew_sat), 0);
    check("midrst_valid", 32'(lvl_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("postrst%0d_valid", i), 32'(lvl_valid), 0);
      check($sformatf("postrst%0d_up", i), 32'(lvl_up), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
